// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer.
// Contents:
//   acq_state_t      - FSM state encoding; also driven out on acq_state
//   MEAS_*           - meas_state codes from the front-panel controller
//   TIME_STATE_MIN/MAX - clamp limits for the timebase index
//   is_pause()       - true for PAUSE and for the unused code 11
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ARM  = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4,
    ST_HOLD = 3'd5
  } acq_state_t;

  localparam logic [1:0] MEAS_RUN    = 2'b00;
  localparam logic [1:0] MEAS_SINGLE = 2'b01;
  localparam logic [1:0] MEAS_PAUSE  = 2'b10;

  localparam int TIME_STATE_MIN = 3;
  localparam int TIME_STATE_MAX = 20;

  // Codes 10 and 11 both mean "stop acquiring".
  function automatic logic is_pause(input logic [1:0] meas);
    return meas[1];
  endfunction

endpackage

// File: rtl/sample_rate_div.sv
// Sample strobe generator.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   clr           - synchronous clear of the divider (setting change)
//   time_state    - timebase index, clamped to TIME_STATE_MIN..TIME_STATE_MAX
//   sample_en     - registered one-cycle strobe every 2^(ts-3) cycles
module sample_rate_div
  import acq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [4:0] time_state,
  output logic       sample_en
);

  logic [4:0]  ts_clamped;
  logic [4:0]  shift;
  logic [16:0] limit;
  logic [16:0] cnt;

  always_comb begin
    ts_clamped = time_state;
    if (time_state < 5'(TIME_STATE_MIN)) ts_clamped = 5'(TIME_STATE_MIN);
    if (time_state > 5'(TIME_STATE_MAX)) ts_clamped = 5'(TIME_STATE_MAX);
    shift = ts_clamped - 5'(TIME_STATE_MIN);
    // limit = 2^shift - 1; at shift=17 the shifted mask is empty, giving all ones.
    limit = ~(17'h1FFFF << shift);
  end

  // '>=' rather than '==' so a timebase change to a faster rate mid-count
  // fires promptly instead of waiting for the counter to wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sample_en <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      sample_en <= 1'b0;
    end else if (cnt >= limit) begin
      cnt       <= '0;
      sample_en <= 1'b1;
    end else begin
      cnt       <= cnt + 17'd1;
      sample_en <= 1'b0;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition frame sequencer: pre-trigger fill, arm (circular fill until a
// trigger or auto timeout), post-trigger fill, then hand-off to the display.
// Ports:
//   sys_clk, sys_rst   - clock, asynchronous active-high reset
//   meas_state         - 00 RUN, 01 SINGLE, 1x PAUSE
//   en_force_trig      - enables the auto-trigger timeout
//   state_change_flag  - one-cycle pulse: a setting changed, restart the frame
//   time_state         - timebase index
//   trig_hit           - trigger comparator, only looked at on sample strobes
//   disp_busy          - display is reading the buffer
//   sample_en          - sample strobe
//   wr_en, wr_addr     - buffer write port
//   trig_addr          - address of the triggering sample
//   frame_done         - one-cycle pulse on entry to DONE
//   armed              - high while in ARM
//   acq_state          - current FSM state
// Write port semantics: a sample is written exactly in the cycles where
// wr_en=1; wr_addr is valid in those cycles and advances by one after each.
// There is no back-pressure from the buffer.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int PRE_TRIG = 256,
  parameter int AUTO_TMO = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        meas_state,
  input  logic              en_force_trig,
  input  logic              state_change_flag,
  input  logic [4:0]        time_state,
  input  logic              trig_hit,
  input  logic              disp_busy,
  output logic              sample_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              frame_done,
  output logic              armed,
  output logic [2:0]        acq_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TMO_W = $clog2(AUTO_TMO + 1);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TMO - 1);

  acq_state_t        state, state_next;
  logic [ADDR_W-1:0] seg_cnt;   // writes so far in PRE or in POST
  logic [TMO_W-1:0]  tmo_cnt;   // strobes seen in ARM, saturates at AUTO_TMO-1
  logic              paused;
  logic              writing;
  logic              restart;
  logic              trig_fire;

  sample_rate_div u_div (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .clr        (state_change_flag),
    .time_state (time_state),
    .sample_en  (sample_en)
  );

  assign paused    = is_pause(meas_state);
  assign writing   = (state == ST_PRE) || (state == ST_ARM) || (state == ST_POST);
  // Decode of two flops (strobe and state), so it carries no input-to-output path.
  assign wr_en     = sample_en & writing;
  assign restart   = writing & state_change_flag & ~paused;
  assign acq_state = state;

  always_comb begin
    state_next = state;
    trig_fire  = 1'b0;
    case (state)
      ST_IDLE: state_next = paused ? ST_HOLD : ST_PRE;
      ST_PRE: begin
        if (paused)                                state_next = ST_HOLD;
        else if (state_change_flag)                state_next = ST_PRE;
        else if (sample_en && seg_cnt == PRE_LAST) state_next = ST_ARM;
      end
      ST_ARM: begin
        if (paused)                 state_next = ST_HOLD;
        else if (state_change_flag) state_next = ST_PRE;
        else if (sample_en && (trig_hit || (en_force_trig && tmo_cnt == TMO_LAST))) begin
          state_next = ST_POST;
          trig_fire  = 1'b1;
        end
      end
      ST_POST: begin
        if (paused)                                 state_next = ST_HOLD;
        else if (state_change_flag)                 state_next = ST_PRE;
        else if (sample_en && seg_cnt == POST_LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!disp_busy) state_next = (meas_state == MEAS_RUN) ? ST_PRE : ST_HOLD;
      end
      ST_HOLD: begin
        if (state_change_flag && !paused) state_next = ST_PRE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      wr_addr    <= '0;
      trig_addr  <= '0;
      seg_cnt    <= '0;
      tmo_cnt    <= '0;
      frame_done <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= (state_next == ST_DONE) && (state != ST_DONE);
      armed      <= (state_next == ST_ARM);
      if (wr_en)     wr_addr   <= wr_addr + ADDR_W'(1);
      if (trig_fire) trig_addr <= wr_addr;
      // Segment counter restarts on every state change and on a setting change.
      if (state_next != state || restart)
        seg_cnt <= '0;
      else if (wr_en && (state == ST_PRE || state == ST_POST))
        seg_cnt <= seg_cnt + ADDR_W'(1);
      // Held at zero outside ARM, so it is clear on every entry to ARM.
      if (state != ST_ARM)
        tmo_cnt <= '0;
      else if (sample_en && tmo_cnt != TMO_LAST)
        tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer with default parameters (1024-deep frame,
// 256 pre-trigger samples, 1024-strobe auto timeout).
module tb_acq_sequencer;
  import acq_pkg::*;

  localparam int POST_LEN = 768;

  // ---------------- clock / reset ----------------
  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] meas_state;
  logic       en_force_trig;
  logic       state_change_flag;
  logic [4:0] time_state;
  logic       trig_hit;
  logic       disp_busy;
  logic       sample_en;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [9:0] trig_addr;
  logic       frame_done;
  logic       armed;
  logic [2:0] acq_state;

  always #5 sys_clk = ~sys_clk;

  acq_sequencer dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .meas_state        (meas_state),
    .en_force_trig     (en_force_trig),
    .state_change_flag (state_change_flag),
    .time_state        (time_state),
    .trig_hit          (trig_hit),
    .disp_busy         (disp_busy),
    .sample_en         (sample_en),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .trig_addr         (trig_addr),
    .frame_done        (frame_done),
    .armed             (armed),
    .acq_state         (acq_state)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];   // expected trig_addr per frame, popped at frame_done
  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  int strobe_cnt = 0;
  int last_wr_cyc = 0;
  int last_strobe = 0;
  int prev_strobe = 0;
  logic [9:0] last_addr = '0;

  // Advance one cycle and observe outputs mid-cycle (negedge).
  task automatic cyc();
    @(negedge sys_clk);
    cyc_no++;
    if (wr_en) begin
      wr_cnt++;
      last_addr   = wr_addr;
      last_wr_cyc = cyc_no;
    end
    if (sample_en) begin
      strobe_cnt++;
      prev_strobe = last_strobe;
      last_strobe = cyc_no;
    end
    if (frame_done) fd_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [4:0] ts, input logic [1:0] meas, input logic frc);
    sys_rst = 1'b1;
    time_state = ts;
    meas_state = meas;
    en_force_trig = frc;
    trig_hit = 1'b0;
    state_change_flag = 1'b0;
    disp_busy = 1'b0;
    repeat (2) cyc();
    wr_cnt = 0;
    fd_cnt = 0;
    strobe_cnt = 0;
    exp_q.delete();
    sys_rst = 1'b0;
  endtask

  task automatic pulse_flag();
    state_change_flag = 1'b1;
    cyc();
    state_change_flag = 1'b0;
  endtask

  task automatic wait_wr(input int n, input int budget, output bit ok);
    int k = 0;
    while (wr_cnt < n && k < budget) begin
      cyc();
      k++;
    end
    ok = (wr_cnt >= n);
  endtask

  task automatic wait_fd(input int budget, output bit ok);
    int k = 0;
    int f = fd_cnt;
    while (fd_cnt == f && k < budget) begin
      cyc();
      k++;
    end
    ok = (fd_cnt > f);
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    int k = 0;
    int s = strobe_cnt;
    while (strobe_cnt < s + n && k < budget) begin
      cyc();
      k++;
    end
    ok = (strobe_cnt >= s + n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sys_rst = 1'b1;
    meas_state = MEAS_RUN;
    time_state = 5'd3;
    en_force_trig = 1'b0;
    state_change_flag = 1'b0;
    trig_hit = 1'b0;
    disp_busy = 1'b0;
    repeat (3) cyc();
    total++; if (sample_en !== 1'b0) begin bad++; $display("FAIL rst_sample_en: got %0d want 0", sample_en); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %0d want 0", wr_en); end
    total++; if (wr_addr !== 10'd0) begin bad++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    total++; if (trig_addr !== 10'd0) begin bad++; $display("FAIL rst_trig_addr: got %0d want 0", trig_addr); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %0d want 0", frame_done); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL rst_armed: got %0d want 0", armed); end
    total++; if (acq_state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", acq_state, ST_IDLE); end
    sys_rst = 1'b0;
    cyc();
    total++; if (acq_state !== ST_PRE) begin bad++; $display("FAIL rst_leave_idle: got %0d want %0d", acq_state, ST_PRE); end
  endtask

  task automatic test_run_trigger();
    bit ok;
    logic [9:0] exp;
    do_reset(5'd3, MEAS_RUN, 1'b0);
    wait_wr(400, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL run_wait400: got %0d want 400", wr_cnt); end
    total++; if (acq_state !== ST_ARM || armed !== 1'b1) begin bad++; $display("FAIL run_armed: got state %0d armed %0d want %0d 1", acq_state, armed, ST_ARM); end
    total++; if (wr_addr !== 10'd399) begin bad++; $display("FAIL run_addr400: got %0d want 399", wr_addr); end
    trig_hit = 1'b1;
    exp_q.push_back(10'd399);
    cyc();
    trig_hit = 1'b0;
    total++; if (acq_state !== ST_POST) begin bad++; $display("FAIL run_trig_latency: got %0d want %0d", acq_state, ST_POST); end
    wait_fd(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL run_frame_done_timeout: got 0 want 1"); end
    else begin
      exp = exp_q.pop_front();
      total++; if (trig_addr !== exp) begin bad++; $display("FAIL run_trig_addr: got %0d want %0d", trig_addr, exp); end
      total++; if (wr_cnt !== 400 + POST_LEN) begin bad++; $display("FAIL run_write_count: got %0d want %0d", wr_cnt, 400 + POST_LEN); end
      total++; if (last_addr !== 10'(exp + 10'd768)) begin bad++; $display("FAIL run_last_addr: got %0d want %0d", last_addr, 10'(exp + 10'd768)); end
      total++; if (cyc_no !== last_wr_cyc + 1) begin bad++; $display("FAIL run_done_timing: got %0d want %0d", cyc_no, last_wr_cyc + 1); end
      total++; if (acq_state !== ST_DONE) begin bad++; $display("FAIL run_done_state: got %0d want %0d", acq_state, ST_DONE); end
      cyc();
      total++; if (acq_state !== ST_PRE) begin bad++; $display("FAIL run_next_pre: got %0d want %0d", acq_state, ST_PRE); end
      total++; if (wr_en !== 1'b1 || wr_addr !== 10'(exp + 10'd769)) begin bad++; $display("FAIL run_next_addr: got %0d want %0d", wr_addr, 10'(exp + 10'd769)); end
    end
  endtask

  task automatic test_auto_trigger();
    bit ok;
    logic [9:0] exp;
    do_reset(5'd5, MEAS_RUN, 1'b1);
    wait_wr(3, 100, ok);
    total++; if (!ok || last_strobe - prev_strobe != 4) begin bad++; $display("FAIL auto_period: got %0d want 4", last_strobe - prev_strobe); end
    wait_wr(1280, 6000, ok);
    total++; if (!ok || acq_state !== ST_ARM) begin bad++; $display("FAIL auto_still_armed: got %0d want %0d", acq_state, ST_ARM); end
    exp_q.push_back(10'd255);
    cyc();
    total++; if (acq_state !== ST_POST) begin bad++; $display("FAIL auto_post_entry: got %0d want %0d", acq_state, ST_POST); end
    wait_fd(4000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL auto_frame_done_timeout: got 0 want 1"); end
    else begin
      exp = exp_q.pop_front();
      total++; if (trig_addr !== exp) begin bad++; $display("FAIL auto_trig_addr: got %0d want %0d", trig_addr, exp); end
      total++; if (last_addr !== 10'd1023) begin bad++; $display("FAIL auto_last_addr: got %0d want 1023", last_addr); end
      total++; if (cyc_no !== last_wr_cyc + 1) begin bad++; $display("FAIL auto_done_timing: got %0d want %0d", cyc_no, last_wr_cyc + 1); end
    end
  endtask

  task automatic test_single();
    bit ok;
    int w0;
    logic [9:0] exp;
    do_reset(5'd3, MEAS_SINGLE, 1'b0);
    for (int f = 0; f < 2; f++) begin
      w0 = wr_cnt;
      wait_wr(w0 + 300, 2000, ok);
      trig_hit = 1'b1;
      exp_q.push_back((f == 0) ? 10'd299 : 10'd343);
      cyc();
      trig_hit = 1'b0;
      wait_fd(2000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL single_frame_timeout: got 0 want 1"); end
      else begin
        exp = exp_q.pop_front();
        total++; if (trig_addr !== exp) begin bad++; $display("FAIL single_trig_addr: got %0d want %0d", trig_addr, exp); end
      end
      cyc();
      total++; if (acq_state !== ST_HOLD) begin bad++; $display("FAIL single_hold: got %0d want %0d", acq_state, ST_HOLD); end
      w0 = wr_cnt;
      repeat (200) cyc();
      total++; if (wr_cnt !== w0) begin bad++; $display("FAIL single_no_writes: got %0d want %0d", wr_cnt, w0); end
      if (f == 0) begin
        meas_state = MEAS_PAUSE;
        repeat (5) cyc();
        meas_state = MEAS_SINGLE;
        pulse_flag();
        total++; if (acq_state !== ST_PRE) begin bad++; $display("FAIL single_rearm: got %0d want %0d", acq_state, ST_PRE); end
      end
    end
    total++; if (fd_cnt !== 2) begin bad++; $display("FAIL single_frame_count: got %0d want 2", fd_cnt); end
  endtask

  task automatic test_pause_post();
    bit ok;
    int w0;
    int f0;
    do_reset(5'd3, MEAS_RUN, 1'b0);
    wait_wr(300, 2000, ok);
    trig_hit = 1'b1;
    cyc();
    trig_hit = 1'b0;
    repeat (100) cyc();
    total++; if (acq_state !== ST_POST) begin bad++; $display("FAIL pause_in_post: got %0d want %0d", acq_state, ST_POST); end
    meas_state = MEAS_PAUSE;
    f0 = fd_cnt;
    cyc();
    total++; if (acq_state !== ST_HOLD) begin bad++; $display("FAIL pause_hold: got %0d want %0d", acq_state, ST_HOLD); end
    w0 = wr_cnt;
    repeat (1000) cyc();
    total++; if (wr_cnt !== w0) begin bad++; $display("FAIL pause_no_writes: got %0d want %0d", wr_cnt, w0); end
    total++; if (fd_cnt !== f0) begin bad++; $display("FAIL pause_no_done: got %0d want %0d", fd_cnt, f0); end
    meas_state = MEAS_RUN;
    pulse_flag();
    total++; if (acq_state !== ST_PRE) begin bad++; $display("FAIL pause_resume: got %0d want %0d", acq_state, ST_PRE); end
  endtask

  task automatic test_settings();
    bit ok;
    int n;
    int s0;
    do_reset(5'd3, MEAS_RUN, 1'b0);
    wait_wr(260, 1000, ok);
    // setting change and trigger in the same strobe: restart wins
    trig_hit = 1'b1;
    pulse_flag();
    trig_hit = 1'b0;
    total++; if (acq_state !== ST_PRE) begin bad++; $display("FAIL set_flag_beats_trig: got %0d want %0d", acq_state, ST_PRE); end
    total++; if (trig_addr !== 10'd0) begin bad++; $display("FAIL set_trig_addr_kept: got %0d want 0", trig_addr); end
    wait_wr(wr_cnt + 260, 1000, ok);
    total++; if (acq_state !== ST_ARM) begin bad++; $display("FAIL set_rearm: got %0d want %0d", acq_state, ST_ARM); end
    time_state = 5'd13;
    wait_strobes(3, 4000, ok);
    total++; if (!ok || last_strobe - prev_strobe != 1024) begin bad++; $display("FAIL set_period13: got %0d want 1024", last_strobe - prev_strobe); end
    repeat (100) cyc();
    pulse_flag();
    total++; if (acq_state !== ST_PRE) begin bad++; $display("FAIL set_restart_arm: got %0d want %0d", acq_state, ST_PRE); end
    n = 0;
    do begin
      cyc();
      n++;
    end while (!sample_en && n < 3000);
    total++; if (n !== 1024) begin bad++; $display("FAIL set_div_clear: got %0d want 1024", n); end
    time_state = 5'd20;
    pulse_flag();
    s0 = strobe_cnt;
    repeat (3000) cyc();
    total++; if (strobe_cnt !== s0) begin bad++; $display("FAIL set_slow_strobe: got %0d want %0d", strobe_cnt, s0); end
    time_state = 5'd0;
    pulse_flag();
    wait_strobes(2, 20, ok);
    total++; if (!ok || last_strobe - prev_strobe != 1) begin bad++; $display("FAIL set_clamp_low: got %0d want 1", last_strobe - prev_strobe); end
  endtask

  task automatic test_busy_reset();
    bit ok;
    int not_done;
    logic [9:0] exp;
    do_reset(5'd3, MEAS_RUN, 1'b0);
    disp_busy = 1'b1;
    wait_wr(300, 2000, ok);
    trig_hit = 1'b1;
    exp_q.push_back(10'd299);
    cyc();
    trig_hit = 1'b0;
    wait_fd(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL busy_frame_timeout: got 0 want 1"); end
    else begin
      exp = exp_q.pop_front();
      total++; if (trig_addr !== exp) begin bad++; $display("FAIL busy_trig_addr: got %0d want %0d", trig_addr, exp); end
    end
    not_done = 0;
    repeat (50) begin
      cyc();
      if (acq_state !== ST_DONE) not_done++;
    end
    total++; if (not_done !== 0) begin bad++; $display("FAIL busy_hold_done: got %0d want 0", not_done); end
    disp_busy = 1'b0;
    cyc();
    total++; if (acq_state !== ST_PRE) begin bad++; $display("FAIL busy_release: got %0d want %0d", acq_state, ST_PRE); end
    wait_wr(wr_cnt + 270, 1000, ok);
    total++; if (acq_state !== ST_ARM) begin bad++; $display("FAIL busy_reach_arm: got %0d want %0d", acq_state, ST_ARM); end
    #2 sys_rst = 1'b1;
    #1;
    total++; if ({sample_en, wr_en, frame_done, armed} !== 4'b0) begin bad++; $display("FAIL arst_flags: got %b want 0000", {sample_en, wr_en, frame_done, armed}); end
    total++; if (wr_addr !== 10'd0) begin bad++; $display("FAIL arst_wr_addr: got %0d want 0", wr_addr); end
    total++; if (trig_addr !== 10'd0) begin bad++; $display("FAIL arst_trig_addr: got %0d want 0", trig_addr); end
    total++; if (acq_state !== ST_IDLE) begin bad++; $display("FAIL arst_state: got %0d want %0d", acq_state, ST_IDLE); end
    cyc();
    sys_rst = 1'b0;
    cyc();
    total++; if (acq_state !== ST_PRE) begin bad++; $display("FAIL arst_leave_idle: got %0d want %0d", acq_state, ST_PRE); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_run_trigger();
    test_auto_trigger();
    test_single();
    test_pause_post();
    test_settings();
    test_busy_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
